mult_rr_arbiter: RTL and testbench

MULT_RR_ARBITER -- requirements
Module: mult_rr_arbiter

---
 rtl/mult_pkg.sv | 26 ++
 rtl/array_multiplier.sv | 57 +++++
 rtl/mult_rr_arbiter.sv | 131 +++++++++++++
 tb/tb_mult_rr_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared defaults for the round-robin multiplier front end, plus the tag record
// that travels alongside the multiplier pipeline.
package mult_pkg;

    localparam int unsigned DATAWIDTH   = 4;
    localparam int unsigned NUM_REQ     = 4;
    localparam int unsigned MUL_LATENCY = 2;

    // Sized for the largest legal requester count so one tag type serves every configuration.
    localparam int unsigned TAG_ID_W    = 4;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    // Index base+off wrapped into 0..n-1 (off is always < n).
    function automatic int unsigned rr_index(input int unsigned base,
                                             input int unsigned off,
                                             input int unsigned n);
        int unsigned s;
        s = base + off;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/array_multiplier.sv
// Unsigned shift-and-add array multiplier followed by LATENCY register stages;
// o_valid/o_z appear exactly LATENCY clocks after i_valid/operands.
module array_multiplier #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_valid,
    output logic [2*WIDTH-1:0]   o_z
);

    localparam int unsigned ZW = 2 * WIDTH;

    logic [ZW-1:0]      prod_c;
    logic [LATENCY-1:0] valid_d, valid_q;
    logic [ZW-1:0]      z_d [LATENCY];
    logic [ZW-1:0]      z_q [LATENCY];

    // Partial-product array: one shifted copy of A per set bit of B.
    always_comb begin
        prod_c = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (i_b[i]) begin
                prod_c = prod_c + (ZW'(i_a) << i);
            end
        end
    end

    always_comb begin
        valid_d[0] = i_valid;
        z_d[0]     = prod_c;
        for (int unsigned s = 1; s < LATENCY; s++) begin
            valid_d[s] = valid_q[s-1];
            z_d[s]     = z_q[s-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int unsigned s = 0; s < LATENCY; s++) begin
                z_q[s] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            z_q     <= z_d;
        end
    end

    assign o_valid = valid_q[LATENCY-1];
    assign o_z     = z_q[LATENCY-1];

endmodule

// File: rtl/mult_rr_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier among NUM_REQ requesters;
// a tag pipeline routes each product back to the requester that issued it.
module mult_rr_arbiter #(
    parameter int unsigned DATAWIDTH   = mult_pkg::DATAWIDTH,
    parameter int unsigned NUM_REQ     = mult_pkg::NUM_REQ,
    parameter int unsigned MUL_LATENCY = mult_pkg::MUL_LATENCY
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ*DATAWIDTH-1:0]       req_a,
    input  logic [NUM_REQ*DATAWIDTH-1:0]       req_b,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic                               hold,
    output logic [NUM_REQ-1:0]                 rsp_valid,
    output logic [2*DATAWIDTH-1:0]             rsp_z,
    output logic [$clog2(NUM_REQ)-1:0]         rsp_id,
    output logic [$clog2(MUL_LATENCY+1)-1:0]   in_flight
);

    import mult_pkg::*;

    localparam int unsigned ID_W = $clog2(NUM_REQ);
    localparam int unsigned IF_W = $clog2(MUL_LATENCY + 1);
    localparam int unsigned ZW   = 2 * DATAWIDTH;

    logic [ID_W-1:0]      ptr_d, ptr_q;
    logic [IF_W-1:0]      in_flight_d, in_flight_q;
    tag_t                 tag_d [MUL_LATENCY];
    tag_t                 tag_q [MUL_LATENCY];

    logic                 grant_c;
    logic [ID_W-1:0]      grant_id_c;
    logic [ID_W-1:0]      cand_c;
    logic [DATAWIDTH-1:0] mul_a_c, mul_b_c;
    logic                 mul_o_valid;
    logic [ZW-1:0]        mul_o_z;
    tag_t                 tag_out_c;
    logic                 rsp_c;

    // First valid requester at or after ptr, wrapping; nothing while in reset or on hold.
    always_comb begin
        grant_c    = 1'b0;
        grant_id_c = '0;
        cand_c     = '0;
        if (!rst && !hold) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                cand_c = ID_W'(rr_index(32'(ptr_q), k, NUM_REQ));
                if (!grant_c && req_valid[cand_c]) begin
                    grant_c    = 1'b1;
                    grant_id_c = cand_c;
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        mul_a_c   = '0;
        mul_b_c   = '0;
        ptr_d     = ptr_q;
        if (grant_c) begin
            req_ready = NUM_REQ'(1) << grant_id_c;
            mul_a_c   = req_a[32'(grant_id_c) * DATAWIDTH +: DATAWIDTH];
            mul_b_c   = req_b[32'(grant_id_c) * DATAWIDTH +: DATAWIDTH];
            ptr_d     = ID_W'(rr_index(32'(grant_id_c), 1, NUM_REQ));
        end
    end

    always_comb begin
        tag_d[0].valid = grant_c;
        tag_d[0].id    = TAG_ID_W'(grant_id_c);
        for (int unsigned s = 1; s < MUL_LATENCY; s++) begin
            tag_d[s] = tag_q[s-1];
        end
    end

    assign tag_out_c = tag_q[MUL_LATENCY-1];

    // A grant and a returning response in the same cycle cancel out.
    always_comb begin
        in_flight_d = in_flight_q + IF_W'(grant_c) - IF_W'(tag_out_c.valid);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            in_flight_q <= '0;
            for (int unsigned s = 0; s < MUL_LATENCY; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            ptr_q       <= ptr_d;
            in_flight_q <= in_flight_d;
            tag_q       <= tag_d;
        end
    end

    array_multiplier #(
        .WIDTH   (DATAWIDTH),
        .LATENCY (MUL_LATENCY)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .i_valid (grant_c),
        .i_a     (mul_a_c),
        .i_b     (mul_b_c),
        .o_valid (mul_o_valid),
        .o_z     (mul_o_z)
    );

    // Response outputs are forced quiet while reset is asserted.
    always_comb begin
        rsp_c     = tag_out_c.valid && !rst;
        rsp_valid = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = rsp_c && (tag_out_c.id == TAG_ID_W'(i));
        end
        rsp_id    = rsp_c ? ID_W'(tag_out_c.id) : '0;
        rsp_z     = rsp_c ? mul_o_z : '0;
        in_flight = rst ? '0 : in_flight_q;
    end

    // Multiplier and tag pipelines must stay in lockstep.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (mul_o_valid == tag_out_c.valid);
        end
    end

endmodule

// File: tb/tb_mult_rr_arbiter.sv
// Self-checking bench for mult_rr_arbiter: directed scenarios plus random traffic,
// all compared against a queue-based transaction model.
module tb_mult_rr_arbiter;

    localparam int unsigned DW  = 4;
    localparam int unsigned NR  = 4;
    localparam int unsigned LAT = 2;
    localparam int unsigned IDW = $clog2(NR);
    localparam int unsigned IFW = $clog2(LAT + 1);
    localparam int unsigned ZW  = 2 * DW;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_a, req_b;
    logic [NR-1:0]     req_ready;
    logic              hold;
    logic [NR-1:0]     rsp_valid;
    logic [ZW-1:0]     rsp_z;
    logic [IDW-1:0]    rsp_id;
    logic [IFW-1:0]    in_flight;

    mult_rr_arbiter #(.DATAWIDTH(DW), .NUM_REQ(NR), .MUL_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .hold(hold), .rsp_valid(rsp_valid), .rsp_z(rsp_z),
        .rsp_id(rsp_id), .in_flight(in_flight)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Transaction model: issued operations waiting for their return cycle.
    typedef struct {
        int due;
        int id;
        int z;
    } exp_t;
    exp_t pend[$];
    int   m_ptr = 0;

    logic [NR-1:0]  e_rdy, e_rsp;
    logic [ZW-1:0]  e_z;
    logic [IDW-1:0] e_id;
    logic [IFW-1:0] e_if;

    function automatic int pick(input logic [NR-1:0] v, input int p);
        for (int k = 0; k < NR; k++) begin
            if (v[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    // Expected outputs for the current cycle (inputs settle first).
    task automatic exp_now(output logic [NR-1:0] rdy, output logic [NR-1:0] rsp,
                           output logic [ZW-1:0] z, output logic [IDW-1:0] id,
                           output logic [IFW-1:0] inf);
        int g;
        #1;
        g   = (rst || hold) ? -1 : pick(req_valid, m_ptr);
        rdy = '0;
        if (g >= 0) rdy[g] = 1'b1;
        rsp = '0;
        z   = '0;
        id  = '0;
        if (!rst && pend.size() > 0 && pend[0].due == cyc) begin
            rsp[pend[0].id] = 1'b1;
            z  = ZW'(pend[0].z);
            id = IDW'(pend[0].id);
        end
        inf = rst ? '0 : IFW'(pend.size());
    endtask

    // Advance one clock and update the model; returns the grant index (-1 if none).
    task automatic tick(output int g);
        int a, b;
        a = 0;
        b = 0;
        g = (rst || hold) ? -1 : pick(req_valid, m_ptr);
        if (g >= 0) begin
            a = int'(req_a[g*DW +: DW]);
            b = int'(req_b[g*DW +: DW]);
        end
        @(posedge clk);
        if (rst) begin
            pend.delete();
            m_ptr = 0;
        end else begin
            if (pend.size() > 0 && pend[0].due == cyc) void'(pend.pop_front());
            if (g >= 0) begin
                pend.push_back('{cyc + LAT, g, a * b});
                m_ptr = (g + 1) % NR;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic new_ops(input int i);
        req_a[i*DW +: DW] = DW'($urandom);
        req_b[i*DW +: DW] = DW'($urandom);
    endtask

    task automatic test_reset();
        int g;
        rst = 1'b1; hold = 1'b0; req_valid = '1;
        for (int i = 0; i < NR; i++) new_ops(i);
        for (int k = 0; k < 2; k++) begin
            exp_now(e_rdy, e_rsp, e_z, e_id, e_if);
            n_checks += 4;
            if (req_ready !== '0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
            if (rsp_valid !== '0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0000", rsp_valid); end
            if (rsp_z !== '0 || rsp_id !== '0) begin n_fail++; $display("FAIL reset_rsp_data got=%0d/%0d exp=0/0", rsp_z, rsp_id); end
            if (in_flight !== '0) begin n_fail++; $display("FAIL reset_in_flight got=%0d exp=0", in_flight); end
            tick(g);
        end
        rst = 1'b0; req_valid = '0;
    endtask

    task automatic test_single();
        int g;
        req_valid = 4'b0001; req_a[3:0] = 4'd3; req_b[3:0] = 4'd5;
        for (int k = 0; k < 4; k++) begin
            exp_now(e_rdy, e_rsp, e_z, e_id, e_if);
            n_checks += 5;
            if (req_ready !== e_rdy) begin n_fail++; $display("FAIL single_ready cyc=%0d got=%b exp=%b", cyc, req_ready, e_rdy); end
            if (rsp_valid !== e_rsp) begin n_fail++; $display("FAIL single_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, e_rsp); end
            if (rsp_z !== e_z) begin n_fail++; $display("FAIL single_rsp_z cyc=%0d got=%0d exp=%0d", cyc, rsp_z, e_z); end
            if (rsp_id !== e_id) begin n_fail++; $display("FAIL single_rsp_id cyc=%0d got=%0d exp=%0d", cyc, rsp_id, e_id); end
            if (in_flight !== e_if) begin n_fail++; $display("FAIL single_in_flight cyc=%0d got=%0d exp=%0d", cyc, in_flight, e_if); end
            if (k == 0) begin
                n_checks++;
                if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_first_grant got=%b exp=0001", req_ready); end
            end
            if (k == 2) begin
                n_checks++;
                if (rsp_valid !== 4'b0001 || rsp_z !== 8'd15 || rsp_id !== 2'd0) begin
                    n_fail++; $display("FAIL single_product got=%b/%0d/%0d exp=0001/15/0", rsp_valid, rsp_z, rsp_id);
                end
            end
            tick(g);
            if (g >= 0) req_valid[g] = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        int g;
        logic [NR-1:0] want;
        rst = 1'b1;
        tick(g);
        rst = 1'b0; req_valid = '1;
        for (int i = 0; i < NR; i++) new_ops(i);
        for (int k = 0; k < 10; k++) begin
            exp_now(e_rdy, e_rsp, e_z, e_id, e_if);
            n_checks += 6;
            if (req_ready !== e_rdy) begin n_fail++; $display("FAIL b2b_ready cyc=%0d got=%b exp=%b", cyc, req_ready, e_rdy); end
            if (rsp_valid !== e_rsp) begin n_fail++; $display("FAIL b2b_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, e_rsp); end
            if (rsp_z !== e_z) begin n_fail++; $display("FAIL b2b_rsp_z cyc=%0d got=%0d exp=%0d", cyc, rsp_z, e_z); end
            if (rsp_id !== e_id) begin n_fail++; $display("FAIL b2b_rsp_id cyc=%0d got=%0d exp=%0d", cyc, rsp_id, e_id); end
            if (in_flight !== e_if) begin n_fail++; $display("FAIL b2b_in_flight cyc=%0d got=%0d exp=%0d", cyc, in_flight, e_if); end
            want = '0;
            want[k % NR] = 1'b1;
            if (req_ready !== want) begin n_fail++; $display("FAIL b2b_order k=%0d got=%b exp=%b", k, req_ready, want); end
            if (k >= 2) begin
                n_checks += 2;
                if (in_flight !== 2'd2) begin n_fail++; $display("FAIL b2b_steady_in_flight k=%0d got=%0d exp=2", k, in_flight); end
                if ($countones(rsp_valid) != 1) begin n_fail++; $display("FAIL b2b_rsp_onehot k=%0d got=%b", k, rsp_valid); end
            end
            tick(g);
            if (g >= 0) new_ops(g);
        end
        req_valid = '0;
    endtask

    task automatic test_max_operands();
        int g;
        req_valid = 4'b1000; req_a[15:12] = 4'd15; req_b[15:12] = 4'd15;
        for (int k = 0; k < 4; k++) begin
            exp_now(e_rdy, e_rsp, e_z, e_id, e_if);
            n_checks += 3;
            if (req_ready !== e_rdy) begin n_fail++; $display("FAIL max_ready cyc=%0d got=%b exp=%b", cyc, req_ready, e_rdy); end
            if (rsp_valid !== e_rsp || rsp_z !== e_z || rsp_id !== e_id) begin
                n_fail++; $display("FAIL max_rsp cyc=%0d got=%b/%0d/%0d exp=%b/%0d/%0d", cyc, rsp_valid, rsp_z, rsp_id, e_rsp, e_z, e_id);
            end
            if (in_flight !== e_if) begin n_fail++; $display("FAIL max_in_flight cyc=%0d got=%0d exp=%0d", cyc, in_flight, e_if); end
            if (k == 2) begin
                n_checks++;
                if (rsp_z !== 8'd225 || rsp_id !== 2'd3) begin n_fail++; $display("FAIL max_product got=%0d/%0d exp=225/3", rsp_z, rsp_id); end
            end
            tick(g);
            if (g >= 0) req_valid[g] = 1'b0;
        end
    endtask

    task automatic test_hold();
        int g;
        req_valid = '1;
        for (int i = 0; i < NR; i++) new_ops(i);
        for (int k = 0; k < 9; k++) begin
            hold = (k >= 2 && k < 5);
            exp_now(e_rdy, e_rsp, e_z, e_id, e_if);
            n_checks += 3;
            if (req_ready !== e_rdy) begin n_fail++; $display("FAIL hold_ready cyc=%0d got=%b exp=%b", cyc, req_ready, e_rdy); end
            if (rsp_valid !== e_rsp || rsp_z !== e_z || rsp_id !== e_id) begin
                n_fail++; $display("FAIL hold_rsp cyc=%0d got=%b/%0d/%0d exp=%b/%0d/%0d", cyc, rsp_valid, rsp_z, rsp_id, e_rsp, e_z, e_id);
            end
            if (in_flight !== e_if) begin n_fail++; $display("FAIL hold_in_flight cyc=%0d got=%0d exp=%0d", cyc, in_flight, e_if); end
            if (hold) begin
                n_checks++;
                if (req_ready !== '0) begin n_fail++; $display("FAIL hold_no_grant k=%0d got=%b exp=0000", k, req_ready); end
            end
            if (k == 4) begin
                n_checks++;
                if (in_flight !== '0) begin n_fail++; $display("FAIL hold_drained got=%0d exp=0", in_flight); end
            end
            tick(g);
            if (g >= 0) new_ops(g);
        end
        hold = 1'b0; req_valid = '0;
    endtask

    task automatic test_reset_midstream();
        int g;
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            rst = (k == 2);
            if (k >= 3 && k < 7) req_valid = '0;
            if (k == 7) req_valid = '1;
            exp_now(e_rdy, e_rsp, e_z, e_id, e_if);
            n_checks += 3;
            if (req_ready !== e_rdy) begin n_fail++; $display("FAIL rstmid_ready cyc=%0d got=%b exp=%b", cyc, req_ready, e_rdy); end
            if (rsp_valid !== e_rsp || rsp_z !== e_z || rsp_id !== e_id) begin
                n_fail++; $display("FAIL rstmid_rsp cyc=%0d got=%b/%0d/%0d exp=%b/%0d/%0d", cyc, rsp_valid, rsp_z, rsp_id, e_rsp, e_z, e_id);
            end
            if (in_flight !== e_if) begin n_fail++; $display("FAIL rstmid_in_flight cyc=%0d got=%0d exp=%0d", cyc, in_flight, e_if); end
            if (k >= 2 && k < 7) begin
                n_checks += 2;
                if (rsp_valid !== '0) begin n_fail++; $display("FAIL rstmid_no_rsp k=%0d got=%b exp=0000", k, rsp_valid); end
                if (in_flight !== '0) begin n_fail++; $display("FAIL rstmid_flushed k=%0d got=%0d exp=0", k, in_flight); end
            end
            if (k == 7) begin
                n_checks++;
                if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rstmid_grant0 got=%b exp=0001", req_ready); end
            end
            tick(g);
            if (g >= 0) new_ops(g);
        end
        rst = 1'b0; req_valid = '0;
    endtask

    task automatic test_random();
        int g;
        for (int k = 0; k < 300; k++) begin
            hold = ($urandom_range(0, 7) == 0);
            exp_now(e_rdy, e_rsp, e_z, e_id, e_if);
            n_checks += 5;
            if (req_ready !== e_rdy) begin n_fail++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, req_ready, e_rdy); end
            if (rsp_valid !== e_rsp) begin n_fail++; $display("FAIL rand_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, e_rsp); end
            if (rsp_z !== e_z) begin n_fail++; $display("FAIL rand_rsp_z cyc=%0d got=%0d exp=%0d", cyc, rsp_z, e_z); end
            if (rsp_id !== e_id) begin n_fail++; $display("FAIL rand_rsp_id cyc=%0d got=%0d exp=%0d", cyc, rsp_id, e_id); end
            if (in_flight !== e_if) begin n_fail++; $display("FAIL rand_in_flight cyc=%0d got=%0d exp=%0d", cyc, in_flight, e_if); end
            tick(g);
            if (g >= 0) req_valid[g] = 1'b0;
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    req_valid[i] = 1'b1;
                    new_ops(i);
                end
            end
        end
        hold = 1'b0; req_valid = '0;
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_max_operands();
        test_hold();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
